// File: rtl/des_trigger_detect.sv
// Watches the DES plaintext stream for a four-word arming sequence and, once it
// completes, raises Tj_Trig for HOLD_CYCLES cycles from a dedicated flop.
module des_trigger_detect #(
    parameter logic [63:0] SEQ0        = 64'h0123456789ABCDEF,
    parameter logic [63:0] SEQ1        = 64'hFEDCBA9876543210,
    parameter logic [63:0] SEQ2        = 64'hA5A5A5A55A5A5A5A,
    parameter logic [63:0] SEQ3        = 64'h0000000000000001,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned MAX_GAP     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    output logic        Tj_Trig,
    output logic [7:0]  trig_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M3   = 3'd3,
        FIRE = 3'd4
    } state_t;

    localparam logic [3:0][63:0] SEQ       = {SEQ3, SEQ2, SEQ1, SEQ0};
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0]      GAP_LIM   = 16'(MAX_GAP);
    localparam bit               GAP_EN    = (MAX_GAP != 0);

    state_t      state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  hold_q, hold_d;
    logic        trig_q, trig_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  hit;
    logic        exp_hit;
    logic        timeout;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_cmp
            assign hit[k] = (data_in == SEQ[k]);
        end
    endgenerate

    // IDLE..M3 encode the number of words matched, so the low bits pick the next word.
    assign exp_hit = hit[state_q[1:0]];
    assign timeout = GAP_EN && (gap_q == GAP_LIM);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gap_d  = 16'd0;
                hold_d = 8'd0;
                trig_d = 1'b0;
                if (data_valid && hit[0]) state_d = M1;
            end
            M1, M2, M3: begin
                // An expired gap wins over whatever word is sampled on the same edge.
                if (timeout) begin
                    state_d = IDLE;
                    gap_d   = 16'd0;
                end else if (data_valid) begin
                    gap_d = 16'd0;
                    if (exp_hit) begin
                        if (state_q == M3) begin
                            state_d = FIRE;
                            trig_d  = 1'b1;
                            hold_d  = 8'd0;
                            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        end else begin
                            state_d = state_t'(state_q + 3'd1);
                        end
                    end else begin
                        state_d = hit[0] ? M1 : IDLE;
                    end
                end else begin
                    gap_d = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
                end
            end
            FIRE: begin
                gap_d = 16'd0;
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    trig_d  = 1'b0;
                    hold_d  = 8'd0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = 16'd0;
                hold_d  = 8'd0;
                trig_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gap_q   <= 16'd0;
            hold_q  <= 8'd0;
            trig_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Tj_Trig    = trig_q;
    assign trig_count = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_des_trigger_detect.sv
// Directed bench: stimulus pushes expected firings, a monitor matches each
// Tj_Trig pulse (rise cycle, trig_count, width) against the queue.
module tb_des_trigger_detect;

    localparam logic [63:0] S0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] S1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] S2 = 64'hA5A5A5A55A5A5A5A;
    localparam logic [63:0] S3 = 64'h0000000000000001;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        data_valid;
    logic        Tj_Trig;
    logic [7:0]  trig_count;
    logic [2:0]  state_dbg;

    typedef struct {
        int rise;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   exp_cnt    = 0;

    des_trigger_detect #(
        .SEQ0(S0), .SEQ1(S1), .SEQ2(S2), .SEQ3(S3),
        .HOLD_CYCLES(HOLD), .MAX_GAP(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_valid(data_valid),
        .Tj_Trig(Tj_Trig),
        .trig_count(trig_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one valid word; if it completes a sequence, queue the expected firing.
    task automatic send(input logic [63:0] w, input bit fires);
        @(negedge clk);
        data_in    = w;
        data_valid = 1'b1;
        if (fires) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            q.push_back('{rise: cyc + 1, cnt: exp_cnt});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
            data_in    = 64'h0;
        end
    endtask

    // Monitor: every rising Tj_Trig must match a queued firing, every pulse is HOLD wide.
    bit in_pulse = 1'b0;
    int len      = 0;
    always @(negedge clk) begin
        if (!rst) begin
            in_pulse = 1'b0;
            len      = 0;
        end else if (Tj_Trig) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                len      = 1;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_firing: got rise at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rise_cycle", 64'(cyc), 64'(e.rise));
                    chk("fire_trig_count", 64'(trig_count), 64'(e.cnt));
                end
            end else begin
                len++;
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            chk("pulse_width", 64'(len), 64'(HOLD));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        data_in    = 64'h0;
        data_valid = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("reset_trig", 64'(Tj_Trig), 64'd0);
        chk("reset_count", 64'(trig_count), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic firing, first word on the first edge after reset release.
        send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 1);
        idle(1);
        chk("fire_state", 64'(state_dbg), 64'd4);
        idle(10);
        chk("after_fire_state", 64'(state_dbg), 64'd0);
        chk("count_1", 64'(trig_count), 64'd1);

        // Restart on SEQ0 in the middle of a partial match.
        send(S0, 0); send(S1, 0); send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 1);
        idle(10);
        chk("count_2", 64'(trig_count), 64'(exp_cnt));

        // Broken sequence.
        send(S0, 0); send(S1, 0); send(S2, 0); send(64'h0, 0);
        idle(1);
        chk("break_state", 64'(state_dbg), 64'd0);
        send(S3, 0);
        idle(2);
        chk("break_no_fire_state", 64'(state_dbg), 64'd0);

        // Repeated SEQ0 keeps M1.
        send(S0, 0); send(S0, 0);
        idle(1);
        chk("repeat_s0_state", 64'(state_dbg), 64'd1);
        send(S1, 0); send(S2, 0); send(S3, 1);
        idle(10);

        // Gap timeout boundary: 1000 idle cycles kills progress, 999 does not.
        send(S0, 0); send(S1, 0);
        idle(1000);
        chk("gap999_state", 64'(state_dbg), 64'd2);
        send(S2, 0); send(S3, 0);
        idle(1);
        chk("timeout_state", 64'(state_dbg), 64'd0);
        send(S0, 0); send(S1, 0);
        idle(999);
        send(S2, 0); send(S3, 1);
        idle(10);

        // Words during FIRE are ignored; re-arming needs the full sequence.
        send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 1);
        send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 0);
        idle(10);
        chk("fire_ignore_state", 64'(state_dbg), 64'd0);
        send(S3, 0);
        idle(2);
        chk("rearm_state", 64'(state_dbg), 64'd0);
        chk("count_pre_reset", 64'(trig_count), 64'(exp_cnt));

        // Async reset during the third high cycle of a firing.
        send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 1);
        idle(3);
        chk("trig_before_reset", 64'(Tj_Trig), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("reset_drop_trig", 64'(Tj_Trig), 64'd0);
        chk("reset_drop_count", 64'(trig_count), 64'd0);
        chk("reset_drop_state", 64'(state_dbg), 64'd0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        send(S1, 0); send(S2, 0); send(S3, 0);
        idle(1);
        chk("no_residual_state", 64'(state_dbg), 64'd0);

        // Saturation: 256 back-to-back sequences, next S0 on the first IDLE edge.
        for (int i = 0; i < 256; i++) begin
            send(S0, 0); send(S1, 0); send(S2, 0); send(S3, 1);
            idle(8);
        end
        idle(4);
        chk("count_saturated", 64'(trig_count), 64'd255);
        chk("pending_firings", 64'(q.size()), 64'd0);
        chk("final_trig", 64'(Tj_Trig), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
